// File: rtl/lbist_pkg.sv
// Shared types, the LFSR polynomial and the Galois step used by both the
// pattern generator and the response compactor of the logic-BIST controller.
package lbist_pkg;

    localparam int SIG_W_DEF = 32;
    localparam int PAT_CNT_W = 16;
    localparam int RST_CNT_W = 8;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [SIG_W_DEF-1:0] POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FLUSH,
        ST_COMPARE,
        ST_DONE
    } state_e;

    function automatic logic [SIG_W_DEF-1:0] lfsr_step(input logic [SIG_W_DEF-1:0] v);
        return (v >> 1) ^ (v[0] ? POLY : '0);
    endfunction

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register: Galois LFSR step folded with the
// incoming response word, with synchronous clear taking priority.
module lbist_misr
    import lbist_pkg::*;
#(
    parameter int unsigned SIG_W = SIG_W_DEF
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [SIG_W-1:0] resp_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] misr_q;
    logic [SIG_W-1:0] misr_d;

    always_comb begin
        misr_d = misr_q;
        if (clr_i) begin
            misr_d = '0;
        end else if (en_i) begin
            misr_d = lfsr_step(misr_q) ^ resp_i;
        end
    end

    always_ff @(posedge clk_i) begin
        misr_q <= misr_d;
    end

    assign sig_o = misr_q;

endmodule

// File: rtl/lbist_controller.sv
// Logic-BIST sequencer: holds the core in reset, streams LFSR patterns,
// compacts responses in a MISR and reports the signature against a golden value.
module lbist_controller
    import lbist_pkg::*;
#(
    parameter int unsigned      SIG_W      = SIG_W_DEF,
    parameter int unsigned      N_PATTERNS = 1024,
    parameter int unsigned      RST_CYCLES = 4,
    parameter logic [SIG_W-1:0] LFSR_SEED  = 32'hACE1_2468,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 32'h0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bist_start_i,
    input  logic             bist_abort_i,
    output logic [SIG_W-1:0] tpg_o,
    input  logic [SIG_W-1:0] resp_i,
    output logic             test_mode_o,
    output logic             core_rst_no,
    output logic             bist_busy_o,
    output logic             bist_done_o,
    output logic             bist_pass_o,
    output logic [SIG_W-1:0] signature_o
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1
    localparam logic [SIG_W-1:0] SEED =
        (LFSR_SEED == '0) ? {{(SIG_W-1){1'b0}}, 1'b1} : LFSR_SEED;
    localparam logic [PAT_CNT_W-1:0] PAT_LAST = PAT_CNT_W'(N_PATTERNS - 1);
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);

    state_e               state_q;
    logic [PAT_CNT_W-1:0] pat_cnt_q;
    logic [RST_CNT_W-1:0] rst_cnt_q;
    logic [SIG_W-1:0]     lfsr_q;
    logic [SIG_W-1:0]     lfsr_d;
    logic                 test_mode_q;
    logic                 core_rst_n_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [SIG_W-1:0]     sig_q;

    logic                 misr_clr;
    logic                 misr_en;
    logic [SIG_W-1:0]     misr_sig;

    assign lfsr_d = lfsr_step(lfsr_q);

    // Responses lag patterns by one cycle: skip the first RUN cycle, catch the last in FLUSH
    assign misr_en  = ((state_q == ST_RUN) && (pat_cnt_q != '0)) || (state_q == ST_FLUSH);
    assign misr_clr = !rst_ni || bist_abort_i || (state_q == ST_IDLE) ||
                      ((state_q == ST_DONE) && bist_start_i);

    lbist_misr #(
        .SIG_W (SIG_W)
    ) u_misr (
        .clk_i  (clk_i),
        .clr_i  (misr_clr),
        .en_i   (misr_en),
        .resp_i (resp_i),
        .sig_o  (misr_sig)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bist_abort_i) begin
            state_q      <= ST_IDLE;
            pat_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            lfsr_q       <= SEED;
            test_mode_q  <= 1'b0;
            core_rst_n_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            sig_q        <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    lfsr_q <= SEED;
                    if (bist_start_i) begin
                        state_q      <= ST_INIT;
                        pat_cnt_q    <= '0;
                        rst_cnt_q    <= '0;
                        test_mode_q  <= 1'b1;
                        core_rst_n_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                ST_INIT: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q      <= ST_RUN;
                        pat_cnt_q    <= '0;
                        rst_cnt_q    <= '0;
                        core_rst_n_q <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    lfsr_q <= lfsr_d;
                    if (pat_cnt_q == PAT_LAST) begin
                        state_q   <= ST_FLUSH;
                        pat_cnt_q <= '0;
                        rst_cnt_q <= '0;
                    end else begin
                        pat_cnt_q <= pat_cnt_q + 16'd1;
                    end
                end
                ST_FLUSH: begin
                    state_q   <= ST_COMPARE;
                    pat_cnt_q <= '0;
                    rst_cnt_q <= '0;
                end
                ST_COMPARE: begin
                    state_q      <= ST_DONE;
                    pat_cnt_q    <= '0;
                    rst_cnt_q    <= '0;
                    pass_q       <= (misr_sig == GOLDEN_SIG);
                    sig_q        <= misr_sig;
                    test_mode_q  <= 1'b0;
                    core_rst_n_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end
                ST_DONE: begin
                    // The old signature stays visible until the next COMPARE
                    if (bist_start_i) begin
                        state_q     <= ST_INIT;
                        pat_cnt_q   <= '0;
                        rst_cnt_q   <= '0;
                        lfsr_q      <= SEED;
                        test_mode_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tpg_o       = lfsr_q;
    assign test_mode_o = test_mode_q;
    assign core_rst_no = core_rst_n_q;
    assign bist_busy_o = busy_q;
    assign bist_done_o = done_q;
    assign bist_pass_o = pass_q;
    assign signature_o = sig_q;

endmodule

// File: tb/tb_lbist_controller.sv
// Randomized bench for lbist_controller: a short configuration exercised with
// random responses, aborts and resets, plus full-length runs against a core model.
module tb_lbist_controller;

    localparam logic [31:0] SEED   = 32'hACE1_2468;
    localparam logic [31:0] POLY_M = 32'h8020_0003;
    localparam int NA = 4;
    localparam int RA = 2;
    localparam int NB = 1024;
    localparam int RB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_a, abort_a, tm_a, crst_a, busy_a, done_a, pass_a;
    logic [31:0] resp_a, tpg_a, sig_a;
    logic        start_b, abort_b, tm_b, crst_b, busy_b, done_b, pass_b;
    logic [31:0] resp_b, tpg_b, sig_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] prev_sig_a;
    bit          prev_known_a;

    lbist_controller #(
        .SIG_W      (32),
        .N_PATTERNS (NA),
        .RST_CYCLES (RA),
        .LFSR_SEED  (SEED),
        .GOLDEN_SIG (32'h0)
    ) dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bist_start_i (start_a),
        .bist_abort_i (abort_a),
        .tpg_o        (tpg_a),
        .resp_i       (resp_a),
        .test_mode_o  (tm_a),
        .core_rst_no  (crst_a),
        .bist_busy_o  (busy_a),
        .bist_done_o  (done_a),
        .bist_pass_o  (pass_a),
        .signature_o  (sig_a)
    );

    lbist_controller dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bist_start_i (start_b),
        .bist_abort_i (abort_b),
        .tpg_o        (tpg_b),
        .resp_i       (resp_b),
        .test_mode_o  (tm_b),
        .core_rst_no  (crst_b),
        .bist_busy_o  (busy_b),
        .bist_done_o  (done_b),
        .bist_pass_o  (pass_b),
        .signature_o  (sig_b)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? POLY_M : 32'h0);
    endfunction

    // {busy, done, test_mode, core_rst_n} expected k cycles after the start edge
    function automatic logic [3:0] exp_ctl(input int k, input int r, input int n);
        if (k < r)         return 4'b1010;
        if (k < r + n + 2) return 4'b1011;
        return 4'b0100;
    endfunction

    function automatic logic [31:0] core_model(input logic [31:0] p, input bit scramble);
        return scramble ? ({p[12:0], p[31:13]} ^ 32'h5A5A_C3C3) : p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            expect_eq(tag, 32'({busy_a, done_a, tm_a, crst_a}), 32'h1);
            expect_eq({tag, "_tpg"}, tpg_a, SEED);
        end
    endtask

    // mode 0: zero responses, 1: a single 1 on one sampled cycle, 2: random words
    task automatic run_a(input int mode, input bit hold, input bit poke);
        logic [31:0] drv [0:15];
        logic [31:0] lf, ms, v;
        int one_at;
        one_at  = RA + 2 + int'($urandom_range(0, NA - 1));
        start_a = 1'b1;
        resp_a  = 32'h0;
        tick();
        if (!hold) start_a = 1'b0;
        lf = SEED;
        for (int off = 0; off <= RA + NA + 2; off++) begin
            expect_eq("a_ctl", 32'({busy_a, done_a, tm_a, crst_a}), 32'(exp_ctl(off, RA, NA)));
            expect_eq("a_tpg", tpg_a, lf);
            if (off >= RA && off < RA + NA) lf = ref_next(lf);
            if (prev_known_a && off <= RA + NA + 1) expect_eq("a_sig_hold", sig_a, prev_sig_a);
            if (mode == 0)      v = 32'h0;
            else if (mode == 1) v = (off + 1 == one_at) ? 32'h1 : 32'h0;
            else                v = $urandom();
            drv[off + 1] = v;
            resp_a = v;
            if (!hold) start_a = (poke && off >= RA && off < RA + NA) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (off < RA + NA + 2) tick();
        end
        ms = 32'h0;
        for (int k = 0; k < NA; k++) ms = ref_next(ms) ^ drv[RA + k + 2];
        expect_eq("a_sig", sig_a, ms);
        expect_eq("a_pass", 32'(pass_a), 32'(ms == 32'h0));
        if (mode == 1) expect_eq("a_sig_nonzero", 32'(sig_a != 32'h0), 32'h1);
        prev_sig_a   = ms;
        prev_known_a = 1'b1;
        start_a      = hold;
    endtask

    task automatic run_b(input bit scramble);
        logic [31:0] lf, ms, pend, pat;
        int lim;
        lim     = RB + NB + 2;
        start_b = 1'b1;
        resp_b  = 32'h0;
        tick();
        start_b = 1'b0;
        lf   = SEED;
        pend = 32'h0;
        for (int off = 0; off <= lim; off++) begin
            expect_eq("b_done", 32'(done_b), 32'(off == lim));
            if (off >= RB && off < RB + NB) begin
                expect_eq("b_tpg", tpg_b, lf);
                lf = ref_next(lf);
            end
            resp_b = pend;
            pend   = core_model(tpg_b, scramble);
            if (off < lim) tick();
        end
        ms  = 32'h0;
        pat = SEED;
        for (int k = 0; k < NB; k++) begin
            ms  = ref_next(ms) ^ core_model(pat, scramble);
            pat = ref_next(pat);
        end
        expect_eq(scramble ? "b_sig_scr" : "b_sig_id", sig_b, ms);
        expect_eq(scramble ? "b_pass_scr" : "b_pass_id", 32'(pass_b), 32'(ms == 32'h0));
        expect_eq("b_ctl_done", 32'({busy_b, done_b, tm_b, crst_b}), 32'h4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst_n   = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; resp_a = 32'h0;
        start_b = 1'b0; abort_b = 1'b0; resp_b = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_eq("rst_ctl_a", 32'({busy_a, done_a, tm_a, crst_a, pass_a}), 32'h2);
            expect_eq("rst_sig_a", sig_a, 32'h0);
            expect_eq("rst_tpg_a", tpg_a, SEED);
            expect_eq("rst_ctl_b", 32'({busy_b, done_b, tm_b, crst_b, pass_b}), 32'h2);
            expect_eq("rst_tpg_b", tpg_b, SEED);
        end
        prev_sig_a   = 32'h0;
        prev_known_a = 1'b1;

        run_a(0, 1'b0, 1'b0);
        run_a(1, 1'b0, 1'b0);
        run_a(2, 1'b0, 1'b1);
        run_a(2, 1'b0, 1'b1);
        run_a(2, 1'b1, 1'b0);
        run_a(2, 1'b0, 1'b0);

        // abort together with start while in DONE
        abort_a = 1'b1;
        start_a = 1'b1;
        tick();
        abort_a = 1'b0;
        start_a = 1'b0;
        expect_eq("abort_done_ctl", 32'({busy_a, done_a, tm_a, crst_a}), 32'h1);
        expect_eq("abort_done_sig", sig_a, 32'h0);
        expect_eq("abort_done_pass", 32'(pass_a), 32'h0);
        idle_a(2, "abort_done_idle");
        prev_sig_a = 32'h0;

        // abort in the middle of RUN
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = RA + int'($urandom_range(0, NA - 1));
        for (int i = 0; i < k; i++) tick();
        expect_eq("pre_abort_busy", 32'(busy_a), 32'h1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        expect_eq("abort_run_ctl", 32'({busy_a, done_a, tm_a, crst_a}), 32'h1);
        expect_eq("abort_run_tpg", tpg_a, SEED);
        idle_a(RA + NA + 4, "abort_run_nodone");
        prev_known_a = 1'b0;
        run_a(2, 1'b0, 1'b0);

        // functional reset during INIT
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        if ($urandom_range(0, 1) == 1) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_eq("rst_init_ctl", 32'({busy_a, done_a, tm_a, crst_a, pass_a}), 32'h2);
        expect_eq("rst_init_sig", sig_a, 32'h0);
        expect_eq("rst_init_tpg", tpg_a, SEED);
        idle_a(RA + NA + 4, "rst_init_nodone");
        prev_sig_a   = 32'h0;
        prev_known_a = 1'b1;
        run_a(2, 1'b0, 1'b0);

        run_b(1'b0);
        tick();
        run_b(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lbist_controller.md
# lbist_controller

Logic-BIST sequencer for the RI5CY core under test. On a start request it forces the core into test mode and holds the core in reset. It then drives pseudo-random patterns from an LFSR into the core's stimulus inputs and compacts the core's responses in a MISR. At the end it compares the signature against a golden value and reports pass/fail. It sits in the test wrapper between the wrapper's `test_mode` pin and the core's `test_mode` and `rst_ni` inputs.

## Interface
Parameters:
- `SIG_W`, 32: LFSR, MISR and signature width.
- `N_PATTERNS`, 1024: number of RUN cycles; legal range 1..2^16-1.
- `RST_CYCLES`, 4: number of cycles the core reset is held in INIT; legal range 1..255.
- `LFSR_SEED`, 32'hACE1_2468: initial LFSR value; 0 is replaced by 1.
- `GOLDEN_SIG`, 32'h0: expected final MISR value.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, synchronous, active-low.
- `bist_start_i`  in  1: start request; sampled only in IDLE or DONE.
- `bist_abort_i`  in  1: abort request; returns the block to IDLE from any state.
- `tpg_o`  out  SIG_W: current LFSR pattern driven to the core stimulus inputs.
- `resp_i`  in  SIG_W: core response word, valid one cycle after the pattern it answers.
- `test_mode_o`  out  1: drives core `test_mode`.
- `core_rst_no`  out  1: core reset, active-low; the wrapper ANDs it with `rst_ni`.
- `bist_busy_o`  out  1: high in INIT, RUN, FLUSH and COMPARE.
- `bist_done_o`  out  1: high in DONE.
- `bist_pass_o`  out  1: result; valid only while `bist_done_o` is high.
- `signature_o`  out  SIG_W: final MISR value, held while in DONE.

## Operation
- FSM states: IDLE, INIT, RUN, FLUSH, COMPARE, DONE.
- IDLE: `test_mode_o`=0, `core_rst_no`=1, LFSR=seed, MISR=0. `bist_start_i`=1 moves to INIT.
- INIT: `test_mode_o`=1, `core_rst_no`=0. Runs for RST_CYCLES cycles, then goes to RUN. LFSR and MISR are held.
- RUN: `test_mode_o`=1, `core_rst_no`=1, for N_PATTERNS cycles.
  - The LFSR advances every cycle.
  - From the 2nd RUN cycle onward, the MISR compacts `resp_i`.
- FLUSH (1 cycle): the MISR compacts the last response. The LFSR is held.
- COMPARE (1 cycle): registers `pass` = (MISR == GOLDEN_SIG) and copies the MISR into `signature_o`.
- DONE: `test_mode_o`=0, `core_rst_no`=0 (the core stays in reset until a new functional reset is applied). The results are held. `bist_start_i` starts a new run, going to INIT with the LFSR reseeded and the MISR cleared.
- Arithmetic: LFSR and MISR are Galois with polynomial x^32+x^22+x^2+x+1.
  - lfsr_next = (lfsr>>1) ^ (lfsr[0] ? POLY : 0).
  - misr_next = step(misr) ^ `resp_i`.
- Counters: a 16-bit pattern counter and an 8-bit reset counter. Both are cleared on every state entry and compared against (param−1). No wrap-around can occur within the legal parameter ranges.

## Timing
- Reset (`rst_ni`=0 at a clock edge) gives IDLE with `test_mode_o`=0, `core_rst_no`=1, `bist_busy_o`=0, `bist_done_o`=0, `bist_pass_o`=0, `signature_o`=0, `tpg_o`=LFSR_SEED.
- Reset mid-run aborts immediately. No result is produced.
- Start sampled at edge t: INIT covers t+1..t+RST_CYCLES.
- RUN covers the next N_PATTERNS cycles, followed by FLUSH, then COMPARE.
- `bist_done_o` rises RST_CYCLES+N_PATTERNS+2 cycles after the start edge.
- `bist_abort_i` has priority over everything else, including a simultaneous start.
  - Next state is IDLE, and `bist_done_o` stays 0.
  - Abort while in DONE clears the results.
- Start while busy is ignored.
- `resp_i` is sampled exactly N_PATTERNS times per run.
- All outputs are registered except `tpg_o`, which is the LFSR register itself.

## Structure
- `lbist_pkg`: the state enum, POLY, default SIG_W, and the `lfsr_step` function.
- Sub-module `lbist_misr`: SIG_W register with clear, enable and compact inputs; it reuses `lfsr_step`.
- The LFSR, counters and FSM live in `lbist_controller`.

## Test plan
- Reset, then idle for 10 cycles: all outputs hold their reset values; `tpg_o`=32'hACE1_2468.
- N_PATTERNS=4, RST_CYCLES=2, `resp_i`=0, GOLDEN_SIG=0, start pulse:
  - `core_rst_no`=0 for exactly 2 cycles.
  - `bist_done_o` rises 8 cycles after the start edge.
  - `bist_pass_o`=1 and `signature_o`=0.
- Same run with `resp_i`=32'h1 on a single RUN cycle: `signature_o`≠0 and `bist_pass_o`=0.
- Full default run with `resp_i` from a reference model of the core: `signature_o` matches the model, and `bist_pass_o`=1 when GOLDEN_SIG is set to the model's value.
- Abort during RUN, and `rst_ni`=0 during INIT:
  - Next cycle is IDLE, `test_mode_o`=0, and `bist_done_o` never rises.
  - A following start produces a signature identical to a clean run.
- Start pulsed during RUN: ignored, and the done timing is unchanged. Start held high in DONE: a new run begins and the previous `signature_o` is held until the next COMPARE.
